// File: rtl/aes_byte_loader.sv
// rtl/aes_byte_loader.sv - byte-stream front end assembling key/plaintext frames for the AES core
module aes_byte_loader #(
  parameter int         CORE_LATENCY = 11,
  parameter logic [7:0] HDR_KEY      = 8'h4B,
  parameter logic [7:0] HDR_DATA     = 8'h44
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] aes_key,
  output logic [127:0] aes_input,
  input  logic [127:0] aes_output,
  output logic [127:0] ct_data,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic         busy,
  output logic         hdr_err
);

  localparam int LAT_W = (CORE_LATENCY < 2) ? 1 : $clog2(CORE_LATENCY + 1);

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_KEY  = 3'd1,
    ST_DATA = 3'd2,
    ST_RUN  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [3:0]         byte_cnt;
  logic [LAT_W-1:0]   lat_cnt;
  logic               key_loaded;
  logic [127:0]       key_stage;
  logic [127:0]       data_stage;
  logic               hdr_err_n;

  logic               accept;
  logic               last_byte;
  logic               lat_done;
  logic [127:0]       key_shift;
  logic [127:0]       data_shift;

  assign in_ready   = (state == ST_HDR) || (state == ST_KEY) || (state == ST_DATA);
  assign busy       = (state != ST_HDR);
  assign accept     = in_valid && in_ready;
  assign last_byte  = (byte_cnt == 4'd15);
  assign lat_done   = (lat_cnt == LAT_W'(CORE_LATENCY - 1));
  // First payload byte ends up in the top byte after sixteen left shifts.
  assign key_shift  = {key_stage[119:0], in_byte};
  assign data_shift = {data_stage[119:0], in_byte};

  always_comb begin
    state_n   = state;
    hdr_err_n = 1'b0;
    case (state)
      ST_HDR: begin
        if (accept) begin
          if (in_byte == HDR_KEY) begin
            state_n = ST_KEY;
          end else if ((in_byte == HDR_DATA) && key_loaded) begin
            state_n = ST_DATA;
          end else begin
            hdr_err_n = 1'b1;
          end
        end
      end
      ST_KEY: begin
        if (accept && last_byte) state_n = ST_HDR;
      end
      ST_DATA: begin
        if (accept && last_byte) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (lat_done) state_n = ST_OUT;
      end
      ST_OUT: begin
        if (ct_valid && ct_ready) state_n = ST_HDR;
      end
      default: state_n = ST_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HDR;
      byte_cnt   <= 4'd0;
      lat_cnt    <= '0;
      key_loaded <= 1'b0;
      key_stage  <= '0;
      data_stage <= '0;
      aes_key    <= '0;
      aes_input  <= '0;
      ct_data    <= '0;
      ct_valid   <= 1'b0;
      hdr_err    <= 1'b0;
    end else begin
      state   <= state_n;
      hdr_err <= hdr_err_n;

      if (accept && (state == ST_KEY)) begin
        key_stage <= key_shift;
        byte_cnt  <= byte_cnt + 4'd1;
        if (last_byte) begin
          aes_key    <= key_shift;
          key_loaded <= 1'b1;
        end
      end

      if (accept && (state == ST_DATA)) begin
        data_stage <= data_shift;
        byte_cnt   <= byte_cnt + 4'd1;
        if (last_byte) begin
          aes_input <= data_shift;
          lat_cnt   <= '0;
        end
      end

      // Capture on the edge that closes the CORE_LATENCY-th RUN cycle.
      if (state == ST_RUN) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
        if (lat_done) begin
          ct_data  <= aes_output;
          ct_valid <= 1'b1;
        end
      end

      if ((state == ST_OUT) && ct_ready) begin
        ct_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_byte_loader.sv
// tb/tb_aes_byte_loader.sv - directed bench for aes_byte_loader with a latency-checking core stub
module tb_aes_byte_loader;

  localparam int CORE_LATENCY = 11;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2      = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] NOT_READY = 128'hdeaddeaddeaddeaddeaddeaddeaddead;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   in_byte = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] aes_key;
  logic [127:0] aes_input;
  logic [127:0] aes_output;
  logic [127:0] ct_data;
  logic         ct_valid;
  logic         ct_ready = 1'b0;
  logic         busy;
  logic         hdr_err;

  int checks = 0;
  int errors = 0;

  aes_byte_loader #(.CORE_LATENCY(CORE_LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .aes_key    (aes_key),
    .aes_input  (aes_input),
    .aes_output (aes_output),
    .ct_data    (ct_data),
    .ct_valid   (ct_valid),
    .ct_ready   (ct_ready),
    .busy       (busy),
    .hdr_err    (hdr_err)
  );

  always #5 clk = ~clk;

  // Core stub: output is only meaningful once key/input have been stable CORE_LATENCY cycles.
  logic [127:0] prev_key = '0;
  logic [127:0] prev_in  = '0;
  int           stable   = 0;
  always @(posedge clk) begin
    prev_key <= aes_key;
    prev_in  <= aes_input;
    if (aes_key == prev_key && aes_input == prev_in) stable <= stable + 1;
    else stable <= 1;
  end
  always_comb begin
    aes_output = NOT_READY;
    if (stable >= CORE_LATENCY - 1) begin
      if (aes_key == FIPS_KEY && aes_input == FIPS_PT) aes_output = FIPS_CT;
      else aes_output = aes_key ^ aes_input;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("in_ready_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [127:0] payload, input int nbytes, input bit gaps);
    send_byte(hdr, gaps);
    for (int i = 0; i < nbytes; i++) send_byte(payload[127 - 8*i -: 8], gaps);
  endtask

  // Returns cycles from the last byte's cycle until ct_valid is seen high.
  task automatic wait_ct(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ct_valid && cyc < 200);
  endtask

  task automatic accept_ct();
    @(negedge clk);
    ct_ready = 1'b1;
    @(negedge clk);
    ct_ready = 1'b0;
  endtask

  int  cyc;
  int  bad;
  logic [127:0] held;

  initial begin
    // 1: reset state, reset mid-KEY discards partial key
    do_reset();
    @(negedge clk);
    check_eq("rst_aes_key", aes_key, '0);
    check_eq("rst_aes_input", aes_input, '0);
    check_eq("rst_ct_valid", 128'(ct_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_in_ready", 128'(in_ready), 128'd1);
    check_eq("rst_hdr_err", 128'(hdr_err), 128'd0);
    send_frame(8'h4B, FIPS_KEY, 7, 1'b0);
    check_eq("partial_key_busy", 128'(busy), 128'd1);
    check_eq("partial_key_no_update", aes_key, '0);
    do_reset();
    check_eq("midkey_rst_busy", 128'(busy), 128'd0);
    check_eq("midkey_rst_key", aes_key, '0);
    send_byte(8'h44, 1'b0);
    check_eq("d_without_key_err", 128'(hdr_err), 128'd1);
    check_eq("d_without_key_state", 128'(busy), 128'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("hdr_err_one_cycle", 128'(hdr_err), 128'd0);

    // 2: FIPS-197 vector, latency
    send_frame(8'h4B, FIPS_KEY, 16, 1'b0);
    check_eq("key_loaded", aes_key, FIPS_KEY);
    check_eq("after_key_busy", 128'(busy), 128'd0);
    send_frame(8'h44, FIPS_PT, 16, 1'b0);
    check_eq("aes_input", aes_input, FIPS_PT);
    check_eq("run_in_ready", 128'(in_ready), 128'd0);
    wait_ct(cyc);
    check_eq("ct_latency", 128'(cyc), 128'(CORE_LATENCY + 1));
    check_eq("ct_fips", ct_data, FIPS_CT);

    // 3: back-pressure in OUT with a pending header byte
    held = ct_data;
    bad = 0;
    in_valid = 1'b1;
    in_byte  = 8'h4B;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ct_valid || ct_data !== held || in_ready) bad++;
    end
    check_eq("out_hold_stable", 128'(bad), 128'd0);
    in_valid = 1'b0;
    accept_ct();
    check_eq("ct_valid_cleared", 128'(ct_valid), 128'd0);
    check_eq("byte_not_consumed", 128'(busy), 128'd0);

    // 4: key reuse, one-cycle ct_valid with ct_ready high, bad header
    ct_ready = 1'b1;
    send_frame(8'h44, FIPS_PT, 16, 1'b0);
    wait_ct(cyc);
    check_eq("reuse_latency", 128'(cyc), 128'(CORE_LATENCY + 1));
    check_eq("reuse_ct", ct_data, FIPS_CT);
    @(negedge clk);
    check_eq("ct_valid_one_cycle", 128'(ct_valid), 128'd0);
    ct_ready = 1'b0;
    send_byte(8'h00, 1'b0);
    check_eq("bad_hdr_err", 128'(hdr_err), 128'd1);
    check_eq("bad_hdr_state", 128'(busy), 128'd0);

    // 5: gappy in_valid
    send_frame(8'h4B, KEY2, 16, 1'b1);
    check_eq("gap_key", aes_key, KEY2);
    send_frame(8'h44, PT2, 16, 1'b1);
    check_eq("gap_input", aes_input, PT2);
    wait_ct(cyc);
    check_eq("gap_latency", 128'(cyc), 128'(CORE_LATENCY + 1));
    check_eq("gap_ct", ct_data, KEY2 ^ PT2);
    accept_ct();

    // 6: key replaced only on 16th byte; partial K then reset clears key
    send_frame(8'h4B, FIPS_KEY, 15, 1'b0);
    check_eq("key_15th_unchanged", aes_key, KEY2);
    send_byte(FIPS_KEY[7:0], 1'b0);
    check_eq("key_16th_replaced", aes_key, FIPS_KEY);
    send_frame(8'h4B, KEY2, 5, 1'b0);
    check_eq("key_partial_unchanged", aes_key, FIPS_KEY);
    do_reset();
    check_eq("key_cleared_by_rst", aes_key, '0);
    send_byte(8'h44, 1'b0);
    check_eq("key_loaded_cleared", 128'(hdr_err), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
